// File: rtl/miss_arbiter_if.sv
// miss_arbiter_if: thread request, memory handshake, response and flush signals of the miss arbiter.
// slave is the arbiter's view; master is the view of the threads and memory around it.
interface miss_arbiter_if #(
    parameter int N_THREADS = 8,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    localparam int TW = $clog2(N_THREADS);
    logic req_valid;
    logic [TW-1:0] req_thread;
    logic req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic req_ready;
    logic mem_req_valid;
    logic mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic mem_req_ready;
    logic mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic resp_valid;
    logic [TW-1:0] resp_thread;
    logic [LINE_W-1:0] resp_data;
    logic [N_THREADS-1:0] stalled;
    logic exc_en;
    logic [TW-1:0] exc_thread;

    modport slave (
        input req_valid, req_thread, req_we, req_addr, req_wdata,
        input mem_req_ready, mem_resp_valid, mem_resp_data, exc_en, exc_thread,
        output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output resp_valid, resp_thread, resp_data, stalled
    );
    modport master (
        output req_valid, req_thread, req_we, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data, exc_en, exc_thread,
        input req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input resp_valid, resp_thread, resp_data, stalled
    );
endinterface

// File: rtl/miss_arbiter.sv
// miss_arbiter: round-robin sharing of one memory port among hardware threads, one transaction in flight.
// Define MISS_ARB_WB_PRIORITY_EN to grant pending writebacks ahead of fills.
module miss_arbiter #(
    parameter int N_THREADS = 8,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input logic clk,
    input logic rst,
    miss_arbiter_if.slave bus
);
    localparam int TW = $clog2(N_THREADS);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [N_THREADS-1:0] pending, slot_we, stalled;
    logic [ADDR_W-1:0] slot_addr [N_THREADS];
    logic [LINE_W-1:0] slot_wdata [N_THREADS];
    logic [TW-1:0] rr_ptr, owner, gnt_id;
    logic gnt_found, do_grant, accept, busy, killed, cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [LINE_W-1:0] cur_wdata, resp_data_q;

    // First set bit of m strictly after p, wrapping; returns {found, index}.
    function automatic logic [TW:0] rr_pick(input logic [N_THREADS-1:0] m, input logic [TW-1:0] p);
        logic [TW:0] r;
        logic [TW-1:0] idx;
        r = '0;
        for (int i = N_THREADS; i >= 1; i--) begin
            idx = TW'((int'(p) + i) % N_THREADS);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

`ifdef MISS_ARB_WB_PRIORITY_EN
    logic [TW:0] wb_pick, all_pick;
    assign wb_pick = rr_pick(pending & slot_we, rr_ptr);
    assign all_pick = rr_pick(pending, rr_ptr);
    assign {gnt_found, gnt_id} = wb_pick[TW] ? wb_pick : all_pick;
`else
    assign {gnt_found, gnt_id} = rr_pick(pending, rr_ptr);
`endif

    assign do_grant = state == IDLE && gnt_found;
    assign bus.req_ready = ~pending[bus.req_thread] & ~(busy && owner == bus.req_thread);
    assign accept = bus.req_valid & bus.req_ready & ~(bus.exc_en && bus.exc_thread == bus.req_thread);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = gnt_found ? ISSUE : IDLE;
            ISSUE: state_n = bus.mem_req_ready ? WAIT : ISSUE;
            WAIT:  state_n = bus.mem_resp_valid ? RESP : WAIT;
            RESP:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            rr_ptr <= TW'(N_THREADS - 1);
        end else begin
            if (accept) pending[bus.req_thread] <= 1'b1;
            if (do_grant) begin
                pending[gnt_id] <= 1'b0;
                rr_ptr <= gnt_id;
            end
            if (bus.exc_en) pending[bus.exc_thread] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_we[bus.req_thread] <= bus.req_we;
            slot_addr[bus.req_thread] <= bus.req_addr;
            slot_wdata[bus.req_thread] <= bus.req_wdata;
        end
    end

    // A killed transaction still runs its memory handshake; only the thread response is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            owner <= '0;
            killed <= 1'b0;
            cur_we <= 1'b0;
            cur_addr <= '0;
            cur_wdata <= '0;
            resp_data_q <= '0;
        end else begin
            if (do_grant) begin
                busy <= 1'b1;
                owner <= gnt_id;
                cur_we <= slot_we[gnt_id];
                cur_addr <= slot_addr[gnt_id];
                cur_wdata <= slot_wdata[gnt_id];
                killed <= bus.exc_en && bus.exc_thread == gnt_id;
            end else if (bus.exc_en && busy && bus.exc_thread == owner) killed <= 1'b1;
            if (state == WAIT && bus.mem_resp_valid) resp_data_q <= bus.mem_resp_data;
            if (state == RESP) busy <= 1'b0;
        end
    end

    always_comb begin
        stalled = pending;
        if (busy) stalled[owner] = 1'b1;
    end

    assign bus.stalled = stalled;
    assign bus.mem_req_valid = state == ISSUE;
    assign bus.mem_req_we = cur_we;
    assign bus.mem_req_addr = cur_addr;
    assign bus.mem_req_wdata = cur_wdata;
    assign bus.resp_valid = state == RESP && !cur_we && !killed;
    assign bus.resp_thread = owner;
    assign bus.resp_data = resp_data_q;
endmodule

// File: tb/tb_miss_arbiter.sv
// tb_miss_arbiter: directed and randomized checks of miss_arbiter against a cycle-level rule model.
module tb_miss_arbiter;
    localparam int N = 8;
    localparam int AW = 32;
    localparam int LW = 128;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    miss_arbiter_if #(.N_THREADS(N), .ADDR_W(AW), .LINE_W(LW)) bus ();
    miss_arbiter #(.N_THREADS(N), .ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: per-thread slots, round-robin pointer, current owner and its handshake phase
    bit m_pend [N];
    bit m_we [N];
    logic [AW-1:0] m_addr [N];
    logic [LW-1:0] m_wd [N];
    int m_rr, m_cur, m_ph, n_resp;
    bit m_kill, c_we;
    logic [AW-1:0] c_addr;
    logic [LW-1:0] c_wd, m_rdata;
    logic [AW-1:0] order [$];
    logic last_rv, last_mrv, last_mwe;
    logic [N-1:0] last_st;
    logic [2:0] last_rt;
    logic [AW-1:0] last_maddr;
    logic [LW-1:0] last_rd, last_mwd;
    logic [AW-1:0] rr_exp [5] = '{32'h700, 32'h000, 32'h200, 32'h500, 32'h010};

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit wb_only);
        for (int k = 1; k <= N; k++) begin
            int t;
            t = (m_rr + k) % N;
            if (m_pend[t] && (!wb_only || m_we[t])) return t;
        end
        return -1;
    endfunction

    function automatic int choose();
        int g;
        g = -1;
`ifdef MISS_ARB_WB_PRIORITY_EN
        g = pick(1'b1);
`endif
        if (g < 0) g = pick(1'b0);
        return g;
    endfunction

    task automatic idle_in();
        bus.req_valid = 1'b0;
        bus.req_thread = '0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.exc_en = 1'b0;
        bus.exc_thread = '0;
    endtask

    task automatic mem_in(input bit r, input bit v);
        bus.mem_req_ready = r;
        bus.mem_resp_valid = v;
    endtask

    task automatic req(input int t, input bit we, input logic [AW-1:0] a, input logic [LW-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_thread = 3'(t);
        bus.req_we = we;
        bus.req_addr = a;
        bus.req_wdata = d;
    endtask

    task automatic exc(input int t);
        bus.exc_en = 1'b1;
        bus.exc_thread = 3'(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        mem_in(1'b0, 1'b0);
        bus.mem_resp_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < N; t++) m_pend[t] = 1'b0;
        m_rr = N - 1;
        m_cur = -1;
        m_ph = 0;
        m_kill = 1'b0;
    endtask

    // check one cycle against the model, then step the model through the clock edge
    task automatic cycle();
        logic [N-1:0] st;
        bit rv, acc;
        int rt, et, g;
        #3;
        rt = int'(bus.req_thread);
        et = int'(bus.exc_thread);
        st = '0;
        for (int t = 0; t < N; t++) st[t] = m_pend[t];
        if (m_cur >= 0) st[m_cur] = 1'b1;
        rv = m_ph == 3 && !c_we && !m_kill;
        chk("stalled", LW'(bus.stalled), LW'(st));
        chk("req_ready", LW'(bus.req_ready), LW'(!(m_pend[rt] || m_cur == rt)));
        chk("mem_req_valid", LW'(bus.mem_req_valid), LW'(m_ph == 1));
        if (m_ph == 1) begin
            chk("mem_req_addr", LW'(bus.mem_req_addr), LW'(c_addr));
            chk("mem_req_we", LW'(bus.mem_req_we), LW'(c_we));
            chk("mem_req_wdata", bus.mem_req_wdata, c_wd);
        end
        chk("resp_valid", LW'(bus.resp_valid), LW'(rv));
        if (rv) begin
            chk("resp_thread", LW'(bus.resp_thread), LW'(m_cur));
            chk("resp_data", bus.resp_data, m_rdata);
            n_resp++;
        end
        last_rv = bus.resp_valid;
        last_mrv = bus.mem_req_valid;
        last_mwe = bus.mem_req_we;
        last_st = bus.stalled;
        last_rt = bus.resp_thread;
        last_maddr = bus.mem_req_addr;
        last_rd = bus.resp_data;
        last_mwd = bus.mem_req_wdata;
        if (bus.mem_req_valid && bus.mem_req_ready) order.push_back(bus.mem_req_addr);
        g = (m_ph == 0) ? choose() : -1;
        acc = bus.req_valid && !m_pend[rt] && m_cur != rt && !(bus.exc_en && et == rt);
        if (bus.exc_en) begin
            if (m_cur == et) m_kill = 1'b1;
            m_pend[et] = 1'b0;
        end
        if (m_ph == 1 && bus.mem_req_ready) m_ph = 2;
        else if (m_ph == 2 && bus.mem_resp_valid) begin
            m_ph = 3;
            m_rdata = bus.mem_resp_data;
        end else if (m_ph == 3) begin
            m_ph = 0;
            m_cur = -1;
        end
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_rr = g;
            m_cur = g;
            m_ph = 1;
            c_we = m_we[g];
            c_addr = m_addr[g];
            c_wd = m_wd[g];
            m_kill = bus.exc_en && et == g;
        end
        if (acc) begin
            m_pend[rt] = 1'b1;
            m_we[rt] = bus.req_we;
            m_addr[rt] = bus.req_addr;
            m_wd[rt] = bus.req_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits;
        n_resp = 0;
        do_reset();
        #3;
        chk("rst_mem_req_valid", LW'(bus.mem_req_valid), LW'(0));
        chk("rst_resp_valid", LW'(bus.resp_valid), LW'(0));
        chk("rst_resp_thread", LW'(bus.resp_thread), LW'(0));
        chk("rst_resp_data", bus.resp_data, LW'(0));
        chk("rst_stalled", LW'(bus.stalled), LW'(0));
        @(posedge clk);
        #1;

        // single fill at minimum latency; resp_valid held high also probes "ignored outside WAIT"
        mem_in(1'b1, 1'b1);
        bus.mem_resp_data = {16{8'hAA}};
        req(3, 1'b0, 32'h100, '0);
        for (int k = 0; k <= 5; k++) begin
            cycle();
            if (k == 0) idle_in();
            chk($sformatf("fill_stall_c%0d", k), LW'(last_st[3]), LW'(k >= 1 && k <= 4));
            chk($sformatf("fill_rv_c%0d", k), LW'(last_rv), LW'(k == 4));
            if (k == 4) begin
                chk("fill_thread", LW'(last_rt), LW'(3));
                chk("fill_data", last_rd, {16{8'hAA}});
            end
        end

        // round robin behind a held transaction from thread 7
        order.delete();
        mem_in(1'b0, 1'b1);
        req(7, 1'b0, 32'h700, '0); cycle();
        req(0, 1'b0, 32'h000, '0); cycle();
        req(2, 1'b0, 32'h200, '0); cycle();
        req(5, 1'b0, 32'h500, '0); cycle();
        idle_in();
        mem_in(1'b1, 1'b1);
        for (int k = 0; k < 40 && order.size() < 3; k++) cycle();
        req(0, 1'b0, 32'h010, '0); cycle();
        idle_in();
        repeat (20) cycle();
        chk("rr_count", LW'(order.size()), LW'(5));
        for (int i = 0; i < 5; i++)
            if (i < order.size()) chk($sformatf("rr_order_%0d", i), LW'(order[i]), LW'(rr_exp[i]));

        // backpressure: request held six cycles with stable fields
        order.delete();
        mem_in(1'b0, 1'b0);
        req(6, 1'b1, 32'h600, {4{32'hDEADBEEF}}); cycle();
        idle_in(); cycle();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) mem_in(1'b1, 1'b0);
            cycle();
            chk($sformatf("bp_valid_%0d", k), LW'(last_mrv), LW'(1));
            chk($sformatf("bp_addr_%0d", k), LW'(last_maddr), LW'(32'h600));
            chk($sformatf("bp_we_%0d", k), LW'(last_mwe), LW'(1));
            chk($sformatf("bp_wdata_%0d", k), last_mwd, {4{32'hDEADBEEF}});
        end
        mem_in(1'b0, 1'b1); cycle();
        mem_in(1'b0, 1'b0); cycle();
        cycle();

        // flush a pending slot, then flush the in-flight owner
        req(4, 1'b0, 32'h400, '0); cycle();
        idle_in(); cycle();
        req(1, 1'b0, 32'h110, '0); cycle();
        idle_in(); exc(1); cycle();
        chk("flush_pend_stall_now", LW'(last_st[1]), LW'(1));
        idle_in(); cycle();
        chk("flush_pend_stall_next", LW'(last_st[1]), LW'(0));
        mem_in(1'b1, 1'b0); cycle();
        mem_in(1'b0, 1'b0); exc(4); cycle();
        idle_in(); cycle();
        mem_in(1'b0, 1'b1); bus.mem_resp_data = {8{16'h5A5A}}; cycle();
        mem_in(1'b0, 1'b0); cycle();
        chk("kill_rv", LW'(last_rv), LW'(0));
        chk("kill_stall_resp", LW'(last_st[4]), LW'(1));
        cycle();
        chk("kill_stall_after", LW'(last_st[4]), LW'(0));
        repeat (6) cycle();
        hits = 0;
        foreach (order[i]) if (order[i] == 32'h110) hits++;
        chk("flush_never_granted", LW'(hits), LW'(0));
        chk("flush_handshakes", LW'(order.size()), LW'(2));

        // writeback priority: fill 0 and writeback 6 pending behind thread 7
        do_reset();
        order.delete();
        req(7, 1'b0, 32'h700, '0); cycle();
        req(0, 1'b0, 32'h000, '0); cycle();
        req(6, 1'b1, 32'h600, {4{32'h12345678}}); cycle();
        idle_in();
        mem_in(1'b1, 1'b1);
        repeat (16) cycle();
        chk("prio_count", LW'(order.size()), LW'(3));
`ifdef MISS_ARB_WB_PRIORITY_EN
        if (order.size() > 1) chk("prio_first", LW'(order[1]), LW'(32'h600));
`else
        if (order.size() > 1) chk("prio_first", LW'(order[1]), LW'(32'h000));
`endif

        // randomized traffic with one mid-run reset
        do_reset();
        n_resp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            bus.req_valid = $urandom_range(0, 9) < 6;
            bus.req_thread = 3'($urandom_range(0, N - 1));
            bus.req_we = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom;
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.exc_en = $urandom_range(0, 19) == 0;
            bus.exc_thread = 3'($urandom_range(0, N - 1));
            if (bus.exc_en && m_ph == 0 && int'(bus.exc_thread) == choose()) bus.exc_en = 1'b0;
            mem_in(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4);
            bus.mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        chk("rand_activity", LW'(n_resp > 20), LW'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
